// File: rtl/jpeg_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_capture_ctrl
// Purpose  : Capture sequencer between the host registers and the JPEG
//            encoder, running on the pixel clock. Latches the per-capture
//            configuration, pulses the encoder start strobe, gates encoder
//            words into the image-buffer write port, and detects completion,
//            timeout, overflow and abort.
// Ports    : pixel_clock_in / pixel_reset_in      clock, sync active-high reset
//            capture_req_in, abort_in             host 1-cycle commands
//            qf/x/y_size_req_in                   requested configuration
//            frame_valid_in                       sensor frame valid
//            enc_*_in                             encoder output stream/status
//            start_capture_out, qf/x/y_size_out   encoder control
//            buf_wr_*_out                         image-buffer write port
//            busy/done/error/image_size/frame_count_out  status
// Revision : 1.0  initial release
// ============================================================================
module jpeg_capture_ctrl #(
  parameter int SENSOR_X_SIZE  = 720,
  parameter int SENSOR_Y_SIZE  = 720,
  parameter int TIMEOUT_FRAMES = 4,
  parameter int BUFFER_WORDS   = 16384,
  localparam int XW = $clog2(SENSOR_X_SIZE),
  localparam int YW = $clog2(SENSOR_Y_SIZE)
) (
  input  logic          pixel_clock_in,
  input  logic          pixel_reset_in,
  input  logic          capture_req_in,
  input  logic          abort_in,
  input  logic [1:0]    qf_select_req_in,
  input  logic [XW-1:0] x_size_req_in,
  input  logic [YW-1:0] y_size_req_in,
  input  logic          frame_valid_in,
  input  logic [31:0]   enc_data_in,
  input  logic [15:0]   enc_address_in,
  input  logic          enc_data_valid_in,
  input  logic          enc_image_valid_in,
  output logic          start_capture_out,
  output logic [1:0]    qf_select_out,
  output logic [XW-1:0] x_size_out,
  output logic [YW-1:0] y_size_out,
  output logic          buf_wr_en_out,
  output logic [13:0]   buf_wr_addr_out,
  output logic [31:0]   buf_wr_data_out,
  output logic          busy_out,
  output logic          done_out,
  output logic [1:0]    error_out,
  output logic [15:0]   image_size_out,
  output logic [7:0]    frame_count_out
);

  localparam logic [31:0] C_BUF_WORDS = 32'(BUFFER_WORDS);
  localparam logic [7:0]  C_TIMEOUT   = 8'(TIMEOUT_FRAMES);

  localparam logic [1:0] C_ERR_NONE    = 2'b00;
  localparam logic [1:0] C_ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] C_ERR_OVFL    = 2'b10;
  localparam logic [1:0] C_ERR_ABORT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_start;
  logic [1:0]    r_qf;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_wr_en;
  logic [13:0]   r_wr_addr;
  logic [31:0]   r_wr_data;
  logic          r_busy;
  logic          r_done;
  logic [1:0]    r_error;
  logic [15:0]   r_image_size;
  logic [7:0]    r_frame_count;
  logic          r_fv_d;

  logic [13:0] w_word_addr;
  logic        w_addr_oob;
  logic        w_overflow;
  logic        w_wr_ok;
  logic        w_frame_end;
  logic [7:0]  w_fc_inc;
  logic        w_timeout;
  logic        w_start_ok;

  assign w_word_addr = enc_address_in[15:2];
  // Compare at 32 bits so any BUFFER_WORDS value (including 16384) is exact.
  assign w_addr_oob  = ({18'd0, w_word_addr} >= C_BUF_WORDS);
  assign w_overflow  = enc_data_valid_in && w_addr_oob;
  assign w_wr_ok     = enc_data_valid_in && !w_addr_oob;
  assign w_frame_end = r_fv_d && !frame_valid_in;
  assign w_fc_inc    = (r_frame_count == 8'hFF) ? 8'hFF : (r_frame_count + 8'd1);
  // Timeout fires on the frame end that brings the count up to the limit.
  assign w_timeout   = w_frame_end && (w_fc_inc == C_TIMEOUT);
  assign w_start_ok  = capture_req_in && !abort_in &&
                       (x_size_req_in != '0) && (y_size_req_in != '0);

  always_ff @(posedge pixel_clock_in) begin
    if (pixel_reset_in) begin
      r_state       <= ST_IDLE;
      r_start       <= 1'b0;
      r_qf          <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= C_ERR_NONE;
      r_image_size  <= '0;
      r_frame_count <= '0;
      r_fv_d        <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_wr_en <= 1'b0;
      r_fv_d  <= frame_valid_in;

      case (r_state)
        ST_CAPTURE: begin
          if (w_frame_end) begin
            r_frame_count <= w_fc_inc;
          end
          // Address/data registers only move on an accepted word.
          if (w_wr_ok) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_word_addr;
            r_wr_data <= enc_data_in;
          end
          // Exit priority: overflow, done, abort, timeout.
          if (w_overflow) begin
            r_state <= ST_ERROR;
            r_busy  <= 1'b0;
            r_error <= C_ERR_OVFL;
          end else if (enc_image_valid_in) begin
            r_state      <= ST_DONE;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_image_size <= enc_address_in;
          end else if (abort_in) begin
            r_state <= ST_ERROR;
            r_busy  <= 1'b0;
            r_error <= C_ERR_ABORT;
          end else if (w_timeout) begin
            r_state <= ST_ERROR;
            r_busy  <= 1'b0;
            r_error <= C_ERR_TIMEOUT;
          end
        end

        default: begin
          // IDLE, DONE and ERROR all accept a new capture and otherwise hold.
          if (w_start_ok) begin
            r_state       <= ST_CAPTURE;
            r_start       <= 1'b1;
            r_qf          <= qf_select_req_in;
            r_x           <= x_size_req_in;
            r_y           <= y_size_req_in;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_error       <= C_ERR_NONE;
            r_image_size  <= '0;
            r_frame_count <= '0;
          end
        end
      endcase
    end
  end

  assign start_capture_out = r_start;
  assign qf_select_out     = r_qf;
  assign x_size_out        = r_x;
  assign y_size_out        = r_y;
  assign buf_wr_en_out     = r_wr_en;
  assign buf_wr_addr_out   = r_wr_addr;
  assign buf_wr_data_out   = r_wr_data;
  assign busy_out          = r_busy;
  assign done_out          = r_done;
  assign error_out         = r_error;
  assign image_size_out    = r_image_size;
  assign frame_count_out   = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_capture_ctrl
// Purpose  : Self-checking bench for jpeg_capture_ctrl. Buffer writes are
//            checked against a scoreboard queue filled when encoder words are
//            driven; control/status outputs are checked inline per scenario.
// Revision : 1.0  initial release
// ============================================================================
module tb_jpeg_capture_ctrl;

  localparam int XW = 10;
  localparam int YW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          capture_req;
  logic          abort;
  logic [1:0]    qf_req;
  logic [XW-1:0] x_req;
  logic [YW-1:0] y_req;
  logic          frame_valid;
  logic [31:0]   enc_data;
  logic [15:0]   enc_addr;
  logic          enc_dv;
  logic          enc_iv;

  logic          start_o;
  logic [1:0]    qf_o;
  logic [XW-1:0] x_o;
  logic [YW-1:0] y_o;
  logic          wr_en_o;
  logic [13:0]   wr_addr_o;
  logic [31:0]   wr_data_o;
  logic          busy_o;
  logic          done_o;
  logic [1:0]    err_o;
  logic [15:0]   size_o;
  logic [7:0]    fc_o;

  jpeg_capture_ctrl #(
    .SENSOR_X_SIZE (720),
    .SENSOR_Y_SIZE (720),
    .TIMEOUT_FRAMES(4),
    .BUFFER_WORDS  (16000)
  ) dut (
    .pixel_clock_in    (clk),
    .pixel_reset_in    (rst),
    .capture_req_in    (capture_req),
    .abort_in          (abort),
    .qf_select_req_in  (qf_req),
    .x_size_req_in     (x_req),
    .y_size_req_in     (y_req),
    .frame_valid_in    (frame_valid),
    .enc_data_in       (enc_data),
    .enc_address_in    (enc_addr),
    .enc_data_valid_in (enc_dv),
    .enc_image_valid_in(enc_iv),
    .start_capture_out (start_o),
    .qf_select_out     (qf_o),
    .x_size_out        (x_o),
    .y_size_out        (y_o),
    .buf_wr_en_out     (wr_en_o),
    .buf_wr_addr_out   (wr_addr_o),
    .buf_wr_data_out   (wr_data_o),
    .busy_out          (busy_o),
    .done_out          (done_o),
    .error_out         (err_o),
    .image_size_out    (size_o),
    .frame_count_out   (fc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer-write monitor: every observed write must match the oldest
  // expected entry, including the cycle it was due in.
  always @(posedge clk) begin
    #2;
    if (wr_en_o === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected: got addr=%0d data=%h at cyc %0d, required no write",
                 wr_addr_o, wr_data_o, cyc);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (e.cyc !== cyc || wr_addr_o !== e.addr || wr_data_o !== e.data) begin
          n_bad++;
          $display("FAIL wr_match: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                   cyc, wr_addr_o, wr_data_o, e.cyc, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [15:0] a, input logic [31:0] d, input bit expect_wr);
    wr_t e;
    enc_dv   = 1'b1;
    enc_addr = a;
    enc_data = d;
    if (expect_wr) begin
      e.cyc  = cyc + 1;
      e.addr = a[15:2];
      e.data = d;
      sb.push_back(e);
    end
  endtask

  task automatic do_start(input logic [1:0] q, input logic [XW-1:0] x, input logic [YW-1:0] y);
    capture_req = 1'b1;
    qf_req      = q;
    x_req       = x;
    y_req       = y;
    tick();
    capture_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (start_o !== 1'b0) begin n_bad++; $display("FAIL rst_start: got %b, required 0", start_o); end
    n_cmp++; if ({qf_o, x_o, y_o} !== '0) begin n_bad++; $display("FAIL rst_cfg: got qf=%0d x=%0d y=%0d, required 0", qf_o, x_o, y_o); end
    n_cmp++; if ({wr_en_o, wr_addr_o, wr_data_o} !== '0) begin n_bad++; $display("FAIL rst_wr: got en=%b addr=%0d data=%h, required 0", wr_en_o, wr_addr_o, wr_data_o); end
    n_cmp++; if ({busy_o, done_o, err_o} !== 4'b0) begin n_bad++; $display("FAIL rst_status: got busy=%b done=%b err=%b, required 0", busy_o, done_o, err_o); end
    n_cmp++; if ({size_o, fc_o} !== '0) begin n_bad++; $display("FAIL rst_size: got size=%h fc=%0d, required 0", size_o, fc_o); end
  endtask

  task automatic test_start();
    do_start(2'd2, 10'd720, 10'd720);
    n_cmp++; if (start_o !== 1'b1) begin n_bad++; $display("FAIL start_pulse: got %b, required 1", start_o); end
    n_cmp++; if (qf_o !== 2'd2 || x_o !== 10'd720 || y_o !== 10'd720) begin n_bad++; $display("FAIL start_cfg: got qf=%0d x=%0d y=%0d, required 2/720/720", qf_o, x_o, y_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL start_busy: got %b, required 1", busy_o); end
    // A request while capturing is ignored.
    do_start(2'd1, 10'd5, 10'd6);
    n_cmp++; if (start_o !== 1'b0) begin n_bad++; $display("FAIL start_width: got %b, required 0", start_o); end
    n_cmp++; if (qf_o !== 2'd2 || x_o !== 10'd720 || y_o !== 10'd720 || busy_o !== 1'b1) begin n_bad++; $display("FAIL req_in_capture: got qf=%0d x=%0d y=%0d busy=%b, required 2/720/720/1", qf_o, x_o, y_o, busy_o); end
  endtask

  task automatic test_writes_done();
    for (int i = 0; i < 3; i++) begin
      drive_word(16'(i * 4), $urandom, 1'b1);
      tick();
    end
    enc_dv = 1'b0;
    tick();
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL wr_drain: got %0d pending, required 0", sb.size()); end
    enc_iv   = 1'b1;
    enc_addr = 16'h1234;
    tick();
    enc_iv   = 1'b0;
    n_cmp++; if (done_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 2'b00) begin n_bad++; $display("FAIL done_state: got done=%b busy=%b err=%b, required 1/0/00", done_o, busy_o, err_o); end
    n_cmp++; if (size_o !== 16'h1234) begin n_bad++; $display("FAIL done_size: got %h, required 1234", size_o); end
    tick();
    n_cmp++; if (done_o !== 1'b1 || size_o !== 16'h1234) begin n_bad++; $display("FAIL done_hold: got done=%b size=%h, required 1/1234", done_o, size_o); end
  endtask

  task automatic test_timeout();
    do_start(2'd1, 10'd320, 10'd240);
    n_cmp++; if (size_o !== 16'h0 || done_o !== 1'b0 || qf_o !== 2'd1 || x_o !== 10'd320) begin n_bad++; $display("FAIL restart_clear: got size=%h done=%b qf=%0d x=%0d, required 0/0/1/320", size_o, done_o, qf_o, x_o); end
    for (int i = 1; i <= 4; i++) begin
      frame_valid = 1'b1;
      tick(); tick();
      frame_valid = 1'b0;
      tick();
      n_cmp++; if (fc_o !== 8'(i)) begin n_bad++; $display("FAIL frame_count: got %0d, required %0d", fc_o, i); end
      if (i < 4) begin
        n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL pre_timeout_busy: got %b, required 1", busy_o); end
      end
    end
    n_cmp++; if (err_o !== 2'b01 || busy_o !== 1'b0 || done_o !== 1'b0) begin n_bad++; $display("FAIL timeout: got err=%b busy=%b done=%b, required 01/0/0", err_o, busy_o, done_o); end
    // No writes outside CAPTURE.
    drive_word(16'h0010, 32'hDEADBEEF, 1'b0);
    tick();
    enc_dv = 1'b0;
    n_cmp++; if (wr_en_o !== 1'b0) begin n_bad++; $display("FAIL wr_in_error: got %b, required 0", wr_en_o); end
    n_cmp++; if (wr_addr_o !== 14'd2) begin n_bad++; $display("FAIL wr_addr_hold: got %0d, required 2", wr_addr_o); end
  endtask

  task automatic test_overflow();
    do_start(2'd3, 10'd16, 10'd16);
    // Last in-range word (15999) is written.
    drive_word(16'hF9FC, 32'h0BADF00D, 1'b1);
    tick();
    drive_word(16'hFFFC, 32'h11111111, 1'b0);
    tick();
    enc_dv = 1'b0;
    n_cmp++; if (err_o !== 2'b10 || busy_o !== 1'b0) begin n_bad++; $display("FAIL overflow: got err=%b busy=%b, required 10/0", err_o, busy_o); end
    n_cmp++; if (wr_en_o !== 1'b0) begin n_bad++; $display("FAIL ovf_no_write: got %b, required 0", wr_en_o); end
    do_start(2'd3, 10'd16, 10'd16);
    drive_word(16'hFA00, 32'h22222222, 1'b0);
    enc_iv = 1'b1;
    tick();
    enc_dv = 1'b0;
    enc_iv = 1'b0;
    n_cmp++; if (err_o !== 2'b10 || done_o !== 1'b0) begin n_bad++; $display("FAIL ovf_vs_done: got err=%b done=%b, required 10/0", err_o, done_o); end
  endtask

  task automatic test_abort();
    do_start(2'd0, 10'd8, 10'd8);
    abort    = 1'b1;
    enc_iv   = 1'b1;
    enc_addr = 16'h0040;
    tick();
    abort  = 1'b0;
    enc_iv = 1'b0;
    n_cmp++; if (done_o !== 1'b1 || err_o !== 2'b00 || size_o !== 16'h0040) begin n_bad++; $display("FAIL done_vs_abort: got done=%b err=%b size=%h, required 1/00/0040", done_o, err_o, size_o); end
    do_start(2'd0, 10'd8, 10'd8);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if (err_o !== 2'b11 || busy_o !== 1'b0) begin n_bad++; $display("FAIL abort: got err=%b busy=%b, required 11/0", err_o, busy_o); end
    test_reset();
    capture_req = 1'b1; abort = 1'b1; x_req = 10'd8; y_req = 10'd8;
    tick();
    capture_req = 1'b0; abort = 1'b0;
    n_cmp++; if (start_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL req_with_abort: got start=%b busy=%b, required 0/0", start_o, busy_o); end
    do_start(2'd1, 10'd0, 10'd8);
    n_cmp++; if (start_o !== 1'b0 || busy_o !== 1'b0 || x_o !== 10'd0) begin n_bad++; $display("FAIL zero_x: got start=%b busy=%b x=%0d, required 0/0/0", start_o, busy_o, x_o); end
    do_start(2'd1, 10'd8, 10'd0);
    n_cmp++; if (start_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL zero_y: got start=%b busy=%b, required 0/0", start_o, busy_o); end
  endtask

  task automatic test_reset_mid();
    do_start(2'd2, 10'd100, 10'd50);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    tick();
    // Word in flight with reset: must be dropped.
    drive_word(16'h0020, 32'hCAFEF00D, 1'b0);
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    enc_dv = 1'b0;
    n_cmp++; if ({start_o, qf_o, x_o, y_o, wr_en_o, wr_addr_o, wr_data_o} !== '0) begin n_bad++; $display("FAIL midrst_ctrl: got start=%b qf=%0d x=%0d y=%0d en=%b addr=%0d data=%h, required 0", start_o, qf_o, x_o, y_o, wr_en_o, wr_addr_o, wr_data_o); end
    n_cmp++; if ({busy_o, done_o, err_o, size_o, fc_o} !== '0) begin n_bad++; $display("FAIL midrst_status: got busy=%b done=%b err=%b size=%h fc=%0d, required 0", busy_o, done_o, err_o, size_o, fc_o); end
    do_start(2'd1, 10'd64, 10'd48);
    n_cmp++; if (start_o !== 1'b1 || qf_o !== 2'd1 || x_o !== 10'd64 || y_o !== 10'd48 || busy_o !== 1'b1) begin n_bad++; $display("FAIL restart: got start=%b qf=%0d x=%0d y=%0d busy=%b, required 1/1/64/48/1", start_o, qf_o, x_o, y_o, busy_o); end
    drive_word(16'h0100, 32'h5A5AA5A5, 1'b1);
    tick();
    enc_dv = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; capture_req = 1'b0; abort = 1'b0;
    qf_req = '0; x_req = '0; y_req = '0; frame_valid = 1'b0;
    enc_data = '0; enc_addr = '0; enc_dv = 1'b0; enc_iv = 1'b0;
    test_reset();
    test_start();
    test_writes_done();
    test_timeout();
    test_overflow();
    test_abort();
    test_reset_mid();
    tick();
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_empty: got %0d pending writes, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
